// File: rtl/ntt_butterfly_unit_pkg.sv
// Shared Kyber NTT parameters, mode encoding and mod-Q add/sub/half helpers.
// Package ntt_params: DATA_W, Q, Barrett constants, latencies, mode_e.
package ntt_params;

  localparam int DATA_W    = 12;
  localparam int Q         = 3329;
  localparam int BARRETT_M = 5039;
  localparam int BARRETT_K = 24;
  localparam int BFU_LAT   = 7;
  localparam int MUL_LAT   = 4;

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } mode_e;

  typedef logic [DATA_W-1:0] coef_t;
  typedef logic [DATA_W:0]   coef_ext_t;

  localparam coef_ext_t QX = coef_ext_t'(Q);

  function automatic coef_t add_mod(coef_t x, coef_t y);
    coef_ext_t s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QX) s = s - QX;
    return s[DATA_W-1:0];
  endfunction

  // MSB of the extended difference is the borrow.
  function automatic coef_t sub_mod(coef_t x, coef_t y);
    coef_ext_t d;
    d = {1'b0, x} - {1'b0, y};
    if (d[DATA_W]) d = d + QX;
    return d[DATA_W-1:0];
  endfunction

`ifdef NTT_BFU_HALF_EN
  // x/2 mod Q: odd values borrow one Q to become even.
  function automatic coef_t half_mod(coef_t x);
    coef_ext_t h;
    h = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
    return h[DATA_W:1];
  endfunction
`endif

endpackage

// File: rtl/ntt_butterfly_unit_if.sv
// Butterfly datapath bundle: operands/mode in, results/valid/busy out.
// master = producer side (drives operands), slave = butterfly unit.
interface ntt_butterfly_unit_if;
  import ntt_params::*;

  logic  valid_in;
  logic  mode;
  coef_t a;
  coef_t b;
  coef_t w;
  logic  valid_out;
  coef_t u;
  coef_t v;
  logic  busy;

  modport master (
    output valid_in, mode, a, b, w,
    input  valid_out, u, v, busy
  );

  modport slave (
    input  valid_in, mode, a, b, w,
    output valid_out, u, v, busy
  );

endinterface

// File: rtl/ntt_butterfly_unit_mod_mul_barrett.sv
// 4-cycle pipelined, valid-free Barrett multiplier: p = x*y mod Q.
// Ports: clk, rst (async high), x, y in [0,Q); p out, 4 cycles later.
module mod_mul_barrett
  import ntt_params::*;
(
  input  logic  clk,
  input  logic  rst,
  input  coef_t x,
  input  coef_t y,
  output coef_t p
);

  localparam int PW = 2 * DATA_W;
  localparam int MW = PW + 13;
  localparam int RW = DATA_W + 2;

  localparam logic [MW-1:0] M_C = MW'(BARRETT_M);
  localparam logic [RW-1:0] Q_R = RW'(Q);

  logic [PW-1:0]     prod_q, prod_d;
  logic [PW-1:0]     prod2_q, prod2_d;
  logic [DATA_W-1:0] t_q, t_d;
  logic [RW-1:0]     r_q, r_d;
  coef_t             p_q, p_d;

  logic [MW-1:0] est;
  logic [RW-1:0] r1, r2;

  // True remainder is < 3Q, so RW-bit wraparound arithmetic is exact.
  always_comb begin
    prod_d  = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
    est     = {{(MW-PW){1'b0}}, prod_q} * M_C;
    t_d     = est[BARRETT_K +: DATA_W];
    prod2_d = prod_q;
    r_d     = prod2_q[RW-1:0] - ({2'b00, t_q} * Q_R);
    r1      = (r_q >= Q_R) ? r_q - Q_R : r_q;
    r2      = (r1 >= Q_R) ? r1 - Q_R : r1;
    p_d     = r2[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      prod2_q <= '0;
      t_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
    end else begin
      prod_q  <= prod_d;
      prod2_q <= prod2_d;
      t_q     <= t_d;
      r_q     <= r_d;
      p_q     <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/ntt_butterfly_unit.sv
// 7-cycle radix-2 Kyber butterfly, CT (mode 0) or GS (mode 1) per sample.
// Ports: clk, rst (async high), bus (slave). Option: NTT_BFU_HALF_EN.
module ntt_butterfly_unit
  import ntt_params::*;
(
  input logic                 clk,
  input logic                 rst,
  ntt_butterfly_unit_if.slave bus
);

  logic  s1_vld_q, s1_vld_d;
  mode_e s1_mode_q, s1_mode_d;
  coef_t s1_a_q, s1_a_d;
  coef_t s1_b_q, s1_b_d;
  coef_t s1_w_q, s1_w_d;

  logic  s2_vld_q, s2_vld_d;
  mode_e s2_mode_q, s2_mode_d;
  coef_t s2_x_q, s2_x_d;
  coef_t s2_y_q, s2_y_d;
  coef_t s2_pass_q, s2_pass_d;

  logic [MUL_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [MUL_LAT-1:0] mode_sr_q, mode_sr_d;
  coef_t pass_sr_q [MUL_LAT];
  coef_t pass_sr_d [MUL_LAT];

  logic  out_vld_q, out_vld_d;
  coef_t u_q, u_d;
  coef_t v_q, v_d;

  coef_t prod;
  coef_t pass_w;

  mod_mul_barrett u_mul (
    .clk (clk),
    .rst (rst),
    .x   (s2_x_q),
    .y   (s2_y_q),
    .p   (prod)
  );

  assign pass_w = pass_sr_q[MUL_LAT-1];

  always_comb begin
    s1_vld_d  = bus.valid_in;
    s1_mode_d = mode_e'(bus.mode);
    s1_a_d    = bus.a;
    s1_b_d    = bus.b;
    s1_w_d    = bus.w;

    s2_vld_d  = s1_vld_q;
    s2_mode_d = s1_mode_q;
    s2_y_d    = s1_w_q;
    s2_x_d    = s1_b_q;
    s2_pass_d = s1_a_q;
    unique case (s1_mode_q)
      MODE_GS: begin
        s2_x_d    = sub_mod(s1_a_q, s1_b_q);
        s2_pass_d = add_mod(s1_a_q, s1_b_q);
      end
      default: ;
    endcase

    vld_sr_d  = {vld_sr_q[MUL_LAT-2:0], s2_vld_q};
    mode_sr_d = {mode_sr_q[MUL_LAT-2:0], s2_mode_q};
    pass_sr_d[0] = s2_pass_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      pass_sr_d[i] = pass_sr_q[i-1];
    end

    out_vld_d = vld_sr_q[MUL_LAT-1];
    u_d       = add_mod(pass_w, prod);
    v_d       = sub_mod(pass_w, prod);
    unique case (mode_e'(mode_sr_q[MUL_LAT-1]))
      MODE_GS: begin
`ifdef NTT_BFU_HALF_EN
        u_d = half_mod(pass_w);
        v_d = half_mod(prod);
`else
        u_d = pass_w;
        v_d = prod;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= MODE_CT;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_w_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_mode_q <= MODE_CT;
      s2_x_q    <= '0;
      s2_y_q    <= '0;
      s2_pass_q <= '0;
      vld_sr_q  <= '0;
      mode_sr_q <= '0;
      pass_sr_q <= '{default: '0};
      out_vld_q <= 1'b0;
      u_q       <= '0;
      v_q       <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_mode_q <= s1_mode_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_w_q    <= s1_w_d;
      s2_vld_q  <= s2_vld_d;
      s2_mode_q <= s2_mode_d;
      s2_x_q    <= s2_x_d;
      s2_y_q    <= s2_y_d;
      s2_pass_q <= s2_pass_d;
      vld_sr_q  <= vld_sr_d;
      mode_sr_q <= mode_sr_d;
      pass_sr_q <= pass_sr_d;
      out_vld_q <= out_vld_d;
      u_q       <= u_d;
      v_q       <= v_d;
    end
  end

  assign bus.valid_out = out_vld_q;
  assign bus.u         = u_q;
  assign bus.v         = v_q;
  assign bus.busy      = s1_vld_q | s2_vld_q | (|vld_sr_q) | out_vld_q;

endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// Self-checking bench for ntt_butterfly_unit: directed cases, reset, random.
// Reference model uses plain modular arithmetic; scoreboard keyed by cycle.
module tb_ntt_butterfly_unit;

  localparam int QM = 3329;

  typedef struct {
    int due;
    int u;
    int v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb [$];

  ntt_butterfly_unit_if bus ();

  ntt_butterfly_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int half_ref(int x);
`ifdef NTT_BFU_HALF_EN
    return (x * 1665) % QM;
`else
    return x;
`endif
  endfunction

  function automatic void ref_bf(input bit m, input int a, input int b,
                                 input int w, output int eu, output int ev);
    int p;
    if (!m) begin
      p  = (b * w) % QM;
      eu = (a + p) % QM;
      ev = (a - p + QM) % QM;
    end else begin
      eu = half_ref((a + b) % QM);
      ev = half_ref((((a - b + QM) % QM) * w) % QM);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    bit ev;
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    chk("busy", 32'(bus.busy), 32'(sb.size() > 0));
    chk("valid_out", 32'(bus.valid_out), 32'(ev));
    if (ev) begin
      chk("u", 32'(bus.u), 32'(sb[0].u));
      chk("v", 32'(bus.v), 32'(sb[0].v));
      chk("u_range", 32'(bus.u < 12'd3329), 32'd1);
      chk("v_range", 32'(bus.v < 12'd3329), 32'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_out();
  endtask

  task automatic drive(input bit vi, input bit m, input int a, input int b,
                       input int w, input int eu, input int ev);
    bus.valid_in = vi;
    bus.mode     = m;
    bus.a        = 12'(a);
    bus.b        = 12'(b);
    bus.w        = 12'(w);
    if (vi) sb.push_back('{cyc + 7, eu, ev});
    tick();
  endtask

  task automatic drive_rand(input bit vi, input bit m);
    int a, b, w, eu, ev;
    a = int'($urandom_range(0, QM - 1));
    b = int'($urandom_range(0, QM - 1));
    w = int'($urandom_range(0, QM - 1));
    ref_bf(m, a, b, w, eu, ev);
    drive(vi, m, a, b, w, eu, ev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.mode     = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.w        = '0;

    #2;
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_u", 32'(bus.u), 32'd0);
    chk("rst_v", 32'(bus.v), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    drive(1'b1, 1'b0, 1, 1, 17, 18, 3313);
    idle(8);

`ifdef NTT_BFU_HALF_EN
    drive(1'b1, 1'b1, 5, 3, 2, 4, 2);
`else
    drive(1'b1, 1'b1, 5, 3, 2, 8, 4);
`endif
    idle(8);

    drive(1'b1, 1'b0, 3328, 3328, 3328, 0, 3327);
`ifdef NTT_BFU_HALF_EN
    drive(1'b1, 1'b1, 3328, 3328, 3328, 3328, 0);
`else
    drive(1'b1, 1'b1, 3328, 3328, 3328, 3327, 0);
`endif
    idle(9);

    for (int i = 0; i < 16; i++) drive_rand(1'b1, i[0]);
    idle(9);

    for (int i = 0; i < 3; i++) drive_rand(1'b1, i[0]);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_u", 32'(bus.u), 32'd0);
    chk("mid_rst_v", 32'(bus.v), 32'd0);
    sb.delete();
    bus.valid_in = 1'b0;
    tick();
    rst = 1'b0;
    idle(10);
    drive_rand(1'b1, 1'b1);
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      drive_rand($urandom_range(0, 7) != 0, 1'($urandom));
    end
    idle(10);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
